// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between the ID stage and the multi-cycle MUL/DIV sequencer.
// master = ID stage side, slave = muldiv_seq.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             rd_hilo;
    logic             cancel;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata, rd_hilo, cancel,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata, rd_hilo, cancel,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO: radix-2 shift-add multiply and
// restoring divide on one work register. Define MULDIV_EARLY_OUT_EN for multiply early exit.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic EarlyOut = 1'b1;
`else
    localparam logic EarlyOut = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e state_q, state_d;

    // Operation context captured at accept
    logic               div_q;
    logic               sa_q;
    logic               sb_q;
    logic               div_zero_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] work_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    // Decoded request
    logic               accept;
    logic               op_div_in;
    logic               op_uns_in;
    logic               sa_in;
    logic               sb_in;
    logic               div_zero_in;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    // Iteration step
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               mul_rest_zero;
    logic               last_iter;

    // Sign fix-up
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // FSM outputs
    logic               idle;
    logic               busy;
    logic               calc_en;
    logic               fix_en;

    always_comb begin
        op_div_in   = bus.op[1];
        op_uns_in   = bus.op[0];
        sa_in       = ~op_uns_in & bus.src_a[WIDTH-1];
        sb_in       = ~op_uns_in & bus.src_b[WIDTH-1];
        abs_a       = sa_in ? -bus.src_a : bus.src_a;
        abs_b       = sb_in ? -bus.src_b : bus.src_b;
        div_zero_in = op_div_in & (bus.src_b == '0);
        accept      = idle & bus.start & ~bus.cancel;
    end

    always_comb begin
        mul_step      = mplier_q[0] ? work_q + mcand_q : work_q;
        // Partial remainder needs one extra bit before the trial subtract
        rem_shift     = work_q[2*WIDTH-1:WIDTH-1];
        rem_diff      = rem_shift - {1'b0, mplier_q};
        div_step      = rem_diff[WIDTH]
                      ? {rem_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                      : {rem_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        mul_rest_zero = (mplier_q >> 1) == '0;
        last_iter     = (cnt_q == CNT_W'(1)) | (EarlyOut & ~div_q & mul_rest_zero);
    end

    always_comb begin
        prod = (sa_q ^ sb_q) ? -work_q : work_q;
        quo  = work_q[WIDTH-1:0];
        rem  = work_q[2*WIDTH-1:WIDTH];
        if (div_zero_q) begin
            // work_q low half holds the raw dividend in this case
            res_hi = work_q[WIDTH-1:0];
            res_lo = '1;
        end else if (div_q) begin
            res_hi = sa_q ? -rem : rem;
            res_lo = (sa_q ^ sb_q) ? -quo : quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = div_zero_in ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (last_iter) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.cancel) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        idle    = (state_q == StIdle);
        busy    = ~idle;
        calc_en = (state_q == StCalc);
        fix_en  = (state_q == StFix) & ~bus.cancel;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            div_q      <= op_div_in;
            sa_q       <= sa_in;
            sb_q       <= sb_in;
            div_zero_q <= div_zero_in;
            cnt_q      <= CNT_W'(WIDTH);
            mcand_q    <= {{WIDTH{1'b0}}, abs_a};
            mplier_q   <= abs_b;
            work_q     <= op_div_in ? {{WIDTH{1'b0}}, (div_zero_in ? bus.src_a : abs_a)}
                                    : '0;
        end else if (calc_en) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (div_q) begin
                work_q <= div_step;
            end else begin
                work_q   <= mul_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fix_en;
            if (fix_en) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (idle & ~bus.start) begin
                // MTHI/MTLO only land when no op is being issued
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy  = busy;
    assign bus.stall = busy & (bus.start | bus.rd_hilo | bus.hi_we | bus.lo_we);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
